// File: rtl/opb_counter_bank_pkg.sv
// Shared constants for the OPB counter bank: register word offsets, CTRL bit positions,
// and the snapshot sequence width.
package opb_counter_bank_pkg;

    localparam logic [7:0] REG_CTRL_W   = 8'd0;
    localparam logic [7:0] REG_STATUS_W = 8'd1;
    localparam logic [7:0] REG_SNAP0_W  = 8'd2;

    localparam int CTRL_SNAP    = 0;
    localparam int CTRL_CLR     = 1;
    localparam int CTRL_AUTOCLR = 2;

    localparam int SEQ_W = 16;

endpackage

// File: rtl/opb_counter_bank_if.sv
// OPB slave attachment signals. Vectors use [31:0], so OPB big-endian bit 0 is value bit 31
// and OPB_BE[3] (the lowest byte lane) is value bit 0.
interface opb_counter_bank_if;
    logic [31:0] OPB_ABus;
    logic [3:0]  OPB_BE;
    logic [31:0] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [31:0] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/counter_channel.sv
// One event channel: live counter, snapshot shadow, and sticky overflow flag.
// The counter and flag update one cycle after an event. The channel never stalls.
module counter_channel #(
    parameter int W        = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         event_i,
    input  logic         snap_i,
    input  logic         clr_i,
    input  logic         autoclr_i,
    output logic [W-1:0] shadow_o,
    output logic         ovf_o
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
    logic         ovf_q, ovf_d;
    logic         at_max;

    assign at_max = (cnt_q == '1);

    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        shadow_d = shadow_q;
        // The shadow always takes the value from before any clear or event in this cycle.
        if (snap_i) shadow_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (event_i && at_max) ovf_d = 1'b1;
            if (snap_i && autoclr_i)
                cnt_d = event_i ? ONE : '0;
            else if (event_i)
                cnt_d = at_max ? (SATURATE ? cnt_q : '0) : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign shadow_o = shadow_q;
    assign ovf_o    = ovf_q;
endmodule

// File: rtl/opb_counter_bank.sv
// OPB slave that exposes a bank of event counters with atomic snapshot, clear and auto-clear.
// The ack comes one cycle after select. Read data is registered. Writes commit in the ack cycle.
module opb_counter_bank
    import opb_counter_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01040200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010402FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_CNT_WIDTH  = 32,
    parameter int          C_SATURATE   = 0
) (
    input  logic                OPB_Clk,
    input  logic                OPB_Rst_n,
    opb_counter_bank_if.slave   bus,
    input  logic [C_NUM_CH-1:0] user_event_in,
    input  logic                user_snap_in
);
    logic [C_OPB_AWIDTH-1:0] addr_v, off_v;
    logic [C_OPB_DWIDTH-1:0] wdat_v, rd_mux, rdata_q, rdata_d;
    logic [3:0]              be_v;
    logic [7:0]              word_off;
    logic                    hit, req, ctrl_wr, snap, clr;
    logic                    ack_q, ack_d, autoclr_q, autoclr_d;
    logic [SEQ_W-1:0]        seq_q, seq_d;
    logic [C_NUM_CH-1:0]     ovf;
    logic [C_CNT_WIDTH-1:0]  shadow [C_NUM_CH];
    logic                    unused_ok;

    assign addr_v   = bus.OPB_ABus;
    assign wdat_v   = bus.OPB_DBus;
    assign be_v     = bus.OPB_BE;
    assign hit      = (addr_v >= C_BASEADDR) && (addr_v <= C_HIGHADDR);
    assign off_v    = addr_v - C_BASEADDR;
    assign word_off = off_v[9:2];
    assign req      = bus.OPB_select & hit;

    // The master holds the address and data through the ack cycle, so the write is decoded there.
    assign ctrl_wr = ack_q & req & ~bus.OPB_RNW & (word_off == REG_CTRL_W) & be_v[0];
    assign snap    = user_snap_in | (ctrl_wr & wdat_v[CTRL_SNAP]);
    assign clr     = ctrl_wr & wdat_v[CTRL_CLR];

    assign ack_d     = req & ~ack_q;
    assign autoclr_d = ctrl_wr ? wdat_v[CTRL_AUTOCLR] : autoclr_q;
    assign seq_d     = snap ? seq_q + SEQ_W'(1) : seq_q;
    assign rdata_d   = (req & ~ack_q & bus.OPB_RNW) ? rd_mux : '0;

    always_comb begin
        rd_mux = '0;
        if (word_off == REG_CTRL_W) begin
            rd_mux[CTRL_AUTOCLR] = autoclr_q;
        end else if (word_off == REG_STATUS_W) begin
            rd_mux[31:16]        = seq_q;
            rd_mux[C_NUM_CH-1:0] = ovf;
        end else begin
            for (int i = 0; i < C_NUM_CH; i++)
                if (word_off == REG_SNAP0_W + 8'(i)) rd_mux[C_CNT_WIDTH-1:0] = shadow[i];
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            autoclr_q <= 1'b0;
            seq_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            autoclr_q <= autoclr_d;
            seq_q     <= seq_d;
        end
    end

    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
        counter_channel #(
            .W        (C_CNT_WIDTH),
            .SATURATE (C_SATURATE != 0)
        ) u_ch (
            .clk       (OPB_Clk),
            .rst_n     (OPB_Rst_n),
            .event_i   (user_event_in[g]),
            .snap_i    (snap),
            .clr_i     (clr),
            .autoclr_i (autoclr_q),
            .shadow_o  (shadow[g]),
            .ovf_o     (ovf[g])
        );
    end

    assign bus.Sl_DBus    = rdata_q;
    assign bus.Sl_xferAck = ack_q;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

    assign unused_ok = ^{bus.OPB_seqAddr, off_v[C_OPB_AWIDTH-1:10], off_v[1:0],
                         wdat_v[C_OPB_DWIDTH-1:3], be_v[3:1]};
endmodule
